// File: rtl/ex_mem_pipe_reg_mc_if.sv
// EX/MEM pipeline register bundle: EX-side request fields and MEM-side registered view.
// master drives EX stage inputs; slave is the pipeline register itself.
interface ex_mem_pipe_reg_mc_if #(
    parameter int XLEN     = 32,
    parameter int FLEN     = 32,
    parameter int PC_W     = 32,
    parameter int CTRL_W   = 8,
    parameter int MC_DEPTH = 4
);
    localparam int CNT_W = $clog2(MC_DEPTH) + 1;

    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [PC_W-1:0]   PC_I;
    logic [4:0]        rd_i;
    logic [XLEN-1:0]   irs2_I;
    logic [FLEN-1:0]   frs2_I;
    logic [CTRL_W-1:0] ctrl_I;
    logic              RegI_Wr_En_I;
    logic              RegF_Wr_En_I;
    logic [1:0]        iSrc_to_Reg_I;
    logic              fSrc_to_Reg_I;
    logic              mc_issue_i;
    logic              mc_done_i;

    logic              valid_O;
    logic [PC_W-1:0]   PC_O;
    logic [4:0]        ex_mem_rd;
    logic [XLEN-1:0]   irs2_O;
    logic [FLEN-1:0]   frs2_O;
    logic [CTRL_W-1:0] ctrl_O;
    logic              RegI_Wr_En_O;
    logic              RegF_Wr_En_O;
    logic [1:0]        iSrc_to_Reg_O;
    logic              fSrc_to_Reg_O;
    logic              mc_result_sel_O;
    logic              mc_ack_O;
    logic              ex_hold_O;
    logic [CNT_W-1:0]  mc_count_O;
    logic              mc_full_O;
    logic              mc_err_O;

    modport master (
        output stall_i, flush_i, valid_i, PC_I, rd_i, irs2_I, frs2_I, ctrl_I,
               RegI_Wr_En_I, RegF_Wr_En_I, iSrc_to_Reg_I, fSrc_to_Reg_I,
               mc_issue_i, mc_done_i,
        input  valid_O, PC_O, ex_mem_rd, irs2_O, frs2_O, ctrl_O, RegI_Wr_En_O,
               RegF_Wr_En_O, iSrc_to_Reg_O, fSrc_to_Reg_O, mc_result_sel_O,
               mc_ack_O, ex_hold_O, mc_count_O, mc_full_O, mc_err_O
    );

    modport slave (
        input  stall_i, flush_i, valid_i, PC_I, rd_i, irs2_I, frs2_I, ctrl_I,
               RegI_Wr_En_I, RegF_Wr_En_I, iSrc_to_Reg_I, fSrc_to_Reg_I,
               mc_issue_i, mc_done_i,
        output valid_O, PC_O, ex_mem_rd, irs2_O, frs2_O, ctrl_O, RegI_Wr_En_O,
               RegF_Wr_En_O, iSrc_to_Reg_O, fSrc_to_Reg_O, mc_result_sel_O,
               mc_ack_O, ex_hold_O, mc_count_O, mc_full_O, mc_err_O
    );
endinterface

// File: rtl/ex_mem_pipe_reg_mc.sv
// EX/MEM pipeline register with stall/flush and an in-order {PC, rd} queue that
// re-injects completed multi-cycle integer ops into MEM as writebacks.
module ex_mem_pipe_reg_mc #(
    parameter int XLEN     = 32,
    parameter int FLEN     = 32,
    parameter int PC_W     = 32,
    parameter int CTRL_W   = 8,
    parameter int MC_DEPTH = 4
) (
    input logic CLK,
    input logic rst_n,
    ex_mem_pipe_reg_mc_if.slave bus
);
    localparam int PTR_W = $clog2(MC_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_irs2;
    logic [FLEN-1:0]   r_frs2;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_regi_we;
    logic              r_regf_we;
    logic [1:0]        r_isrc;
    logic              r_fsrc;
    logic              r_mc_sel;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PC_W-1:0]   r_q_pc [MC_DEPTH];
    logic [4:0]        r_q_rd [MC_DEPTH];

    logic w_full, w_empty, w_pop, w_push, w_hold, w_bubble, w_done_empty;

    assign w_full       = (r_count == CNT_W'(MC_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pop        = bus.mc_done_i & ~bus.stall_i & ~w_empty;
    assign w_done_empty = bus.mc_done_i & ~bus.stall_i & w_empty;

    // A full queue still accepts an issue when the oldest entry leaves in the same cycle,
    // so EX only holds on a full queue when nothing is draining.
    assign w_push = bus.mc_issue_i & bus.valid_i & ~bus.stall_i & ~bus.flush_i
                  & (~w_full | w_pop);
    assign w_hold = ~bus.stall_i & ~bus.flush_i & bus.valid_i
                  & ((w_pop & ~bus.mc_issue_i) | (bus.mc_issue_i & w_full & ~w_pop));
    assign w_bubble = bus.flush_i | w_push | w_hold | ~bus.valid_i;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_irs2    <= '0;
            r_frs2    <= '0;
            r_ctrl    <= '0;
            r_regi_we <= 1'b0;
            r_regf_we <= 1'b0;
            r_isrc    <= '0;
            r_fsrc    <= 1'b0;
            r_mc_sel  <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else if (!bus.stall_i) begin
            if (w_done_empty)
                r_err <= 1'b1;

            if (w_pop) begin
                r_valid   <= 1'b1;
                r_pc      <= r_q_pc[r_rptr];
                r_rd      <= r_q_rd[r_rptr];
                r_irs2    <= '0;
                r_frs2    <= '0;
                r_ctrl    <= '0;
                r_regi_we <= 1'b1;
                r_regf_we <= 1'b0;
                r_isrc    <= 2'b00;
                r_fsrc    <= 1'b0;
                r_mc_sel  <= 1'b1;
            end else if (w_bubble) begin
                r_valid   <= 1'b0;
                r_ctrl    <= '0;
                r_regi_we <= 1'b0;
                r_regf_we <= 1'b0;
                r_mc_sel  <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_pc      <= bus.PC_I;
                r_rd      <= bus.rd_i;
                r_irs2    <= bus.irs2_I;
                r_frs2    <= bus.frs2_I;
                r_ctrl    <= bus.ctrl_I;
                r_regi_we <= bus.RegI_Wr_En_I;
                r_regf_we <= bus.RegF_Wr_En_I;
                r_isrc    <= bus.iSrc_to_Reg_I;
                r_fsrc    <= bus.fSrc_to_Reg_I;
                r_mc_sel  <= 1'b0;
            end

            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Queue storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_wptr] <= bus.PC_I;
            r_q_rd[r_wptr] <= bus.rd_i;
        end
    end

    assign bus.valid_O         = r_valid;
    assign bus.PC_O            = r_pc;
    assign bus.ex_mem_rd       = r_rd;
    assign bus.irs2_O          = r_irs2;
    assign bus.frs2_O          = r_frs2;
    assign bus.ctrl_O          = r_ctrl;
    assign bus.RegI_Wr_En_O    = r_regi_we;
    assign bus.RegF_Wr_En_O    = r_regf_we;
    assign bus.iSrc_to_Reg_O   = r_isrc;
    assign bus.fSrc_to_Reg_O   = r_fsrc;
    assign bus.mc_result_sel_O = r_mc_sel;
    assign bus.mc_ack_O        = w_pop;
    assign bus.ex_hold_O       = w_hold;
    assign bus.mc_count_O      = r_count;
    assign bus.mc_full_O       = w_full;
    assign bus.mc_err_O        = r_err;
endmodule

// File: tb/tb_ex_mem_pipe_reg_mc.sv
// Self-checking bench for ex_mem_pipe_reg_mc: directed scenarios plus a random run
// against a queue-based reference model.
module tb_ex_mem_pipe_reg_mc;
    localparam int XLEN = 32, FLEN = 32, PC_W = 32, CTRL_W = 8, MC_DEPTH = 4;
    localparam int CNT_W = $clog2(MC_DEPTH) + 1;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    ex_mem_pipe_reg_mc_if #(.XLEN(XLEN), .FLEN(FLEN), .PC_W(PC_W), .CTRL_W(CTRL_W),
                            .MC_DEPTH(MC_DEPTH)) bus ();

    ex_mem_pipe_reg_mc #(.XLEN(XLEN), .FLEN(FLEN), .PC_W(PC_W), .CTRL_W(CTRL_W),
                         .MC_DEPTH(MC_DEPTH)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [PC_W-1:0] pc; logic [4:0] rd; } ent_t;
    ent_t mq[$];

    logic              m_valid, m_regi, m_regf, m_fsrc, m_sel, m_err;
    logic [PC_W-1:0]   m_pc;
    logic [4:0]        m_rd;
    logic [XLEN-1:0]   m_irs2;
    logic [FLEN-1:0]   m_frs2;
    logic [CTRL_W-1:0] m_ctrl;
    logic [1:0]        m_isrc;

    task automatic model_reset();
        mq.delete();
        m_valid = 0; m_regi = 0; m_regf = 0; m_fsrc = 0; m_sel = 0; m_err = 0;
        m_pc = '0; m_rd = '0; m_irs2 = '0; m_frs2 = '0; m_ctrl = '0; m_isrc = '0;
    endtask

    function automatic void model_comb(output bit pop, output bit push, output bit hold);
        bit full;
        full = (mq.size() == MC_DEPTH);
        pop  = bus.mc_done_i && !bus.stall_i && mq.size() != 0;
        push = bus.mc_issue_i && bus.valid_i && !bus.stall_i && !bus.flush_i && (!full || pop);
        hold = !bus.stall_i && !bus.flush_i && bus.valid_i &&
               ((pop && !bus.mc_issue_i) || (bus.mc_issue_i && full && !pop));
    endfunction

    task automatic model_step();
        bit pop, push, hold;
        ent_t e;
        model_comb(pop, push, hold);
        if (bus.stall_i) return;
        if (bus.mc_done_i && mq.size() == 0) m_err = 1;
        if (pop) begin
            e = mq.pop_front();
            m_valid = 1; m_pc = e.pc; m_rd = e.rd; m_regi = 1; m_isrc = 0; m_regf = 0;
            m_fsrc = 0; m_ctrl = 0; m_irs2 = 0; m_frs2 = 0; m_sel = 1;
        end else if (bus.flush_i || push || hold || !bus.valid_i) begin
            m_valid = 0; m_regi = 0; m_regf = 0; m_ctrl = 0; m_sel = 0;
        end else begin
            m_valid = 1; m_pc = bus.PC_I; m_rd = bus.rd_i; m_irs2 = bus.irs2_I;
            m_frs2 = bus.frs2_I; m_ctrl = bus.ctrl_I; m_regi = bus.RegI_Wr_En_I;
            m_regf = bus.RegF_Wr_En_I; m_isrc = bus.iSrc_to_Reg_I; m_fsrc = bus.fSrc_to_Reg_I;
            m_sel = 0;
        end
        if (push) mq.push_back('{pc: bus.PC_I, rd: bus.rd_i});
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        bus.stall_i = 0; bus.flush_i = 0; bus.valid_i = 0; bus.PC_I = '0; bus.rd_i = '0;
        bus.irs2_I = '0; bus.frs2_I = '0; bus.ctrl_I = '0; bus.RegI_Wr_En_I = 0;
        bus.RegF_Wr_En_I = 0; bus.iSrc_to_Reg_I = '0; bus.fSrc_to_Reg_I = 0;
        bus.mc_issue_i = 0; bus.mc_done_i = 0;
    endtask

    task automatic drive_ex(input logic [PC_W-1:0] pc, input logic [4:0] rd, input logic issue);
        bus.valid_i = 1; bus.PC_I = pc; bus.rd_i = rd; bus.RegI_Wr_En_I = 1; bus.mc_issue_i = issue;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        model_reset();
        #12;
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O} !== '0) begin
            n_fail++; $display("FAIL reset_regs got v=%b pc=%h rd=%0d ctrl=%h want all 0", bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O); end
        n_chk++; if ({bus.mc_count_O, bus.mc_full_O, bus.mc_err_O, bus.mc_result_sel_O, bus.mc_ack_O, bus.ex_hold_O} !== '0) begin
            n_fail++; $display("FAIL reset_status got cnt=%0d full=%b err=%b sel=%b want 0", bus.mc_count_O, bus.mc_full_O, bus.mc_err_O, bus.mc_result_sel_O); end
        @(negedge CLK);
        rst_n = 1;
    endtask

    task automatic test_normal();
        @(negedge CLK);
        drive_idle(); drive_ex(32'h100, 5'd5, 0); bus.ctrl_I = 8'h40; bus.irs2_I = 32'hDEAD_BEEF; bus.iSrc_to_Reg_I = 2'b01;
        tick();
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O, bus.RegI_Wr_En_O, bus.mc_result_sel_O} !== {1'b1, 32'h100, 5'd5, 8'h40, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL normal_a got v=%b pc=%h rd=%0d ctrl=%h we=%b sel=%b want 1/100/5/40/1/0", bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O, bus.RegI_Wr_En_O, bus.mc_result_sel_O); end
        n_chk++; if ({bus.irs2_O, bus.iSrc_to_Reg_O} !== {32'hDEAD_BEEF, 2'b01}) begin
            n_fail++; $display("FAIL normal_data got irs2=%h isrc=%0d want deadbeef/1", bus.irs2_O, bus.iSrc_to_Reg_O); end
        @(negedge CLK);
        drive_idle(); bus.valid_i = 1; bus.PC_I = 32'h104; bus.rd_i = 5'd0; bus.RegF_Wr_En_I = 1;
        bus.frs2_I = 32'h3F80_0000; bus.fSrc_to_Reg_I = 1; bus.ctrl_I = 8'h22;
        tick();
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O, bus.frs2_O, bus.fSrc_to_Reg_O, bus.ctrl_O} !== {1'b1, 32'h104, 1'b0, 1'b1, 32'h3F80_0000, 1'b1, 8'h22}) begin
            n_fail++; $display("FAIL normal_fp got v=%b pc=%h wi=%b wf=%b frs2=%h fsrc=%b ctrl=%h", bus.valid_O, bus.PC_O, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O, bus.frs2_O, bus.fSrc_to_Reg_O, bus.ctrl_O); end
    endtask

    task automatic test_stall_flush();
        @(negedge CLK);
        drive_idle(); drive_ex(32'h180, 5'd11, 0); bus.ctrl_I = 8'h81;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive_idle(); bus.stall_i = 1; drive_ex(32'h1F0 + 32'(i), 5'd30, 0); bus.ctrl_I = 8'hFF;
            #1;
            n_chk++; if (bus.ex_hold_O !== 1'b0) begin n_fail++; $display("FAIL stall_hold got %b want 0", bus.ex_hold_O); end
            tick();
            n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O} !== {1'b1, 32'h180, 5'd11, 8'h81}) begin
                n_fail++; $display("FAIL stall_freeze%0d got v=%b pc=%h rd=%0d ctrl=%h want 1/180/11/81", i, bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O); end
        end
        @(negedge CLK);
        drive_idle(); bus.flush_i = 1; drive_ex(32'h1C0, 5'd12, 0); bus.ctrl_I = 8'h40;
        tick();
        n_chk++; if ({bus.valid_O, bus.RegI_Wr_En_O, bus.ctrl_O} !== '0) begin
            n_fail++; $display("FAIL flush got v=%b we=%b ctrl=%h want 0/0/00", bus.valid_O, bus.RegI_Wr_En_O, bus.ctrl_O); end
    endtask

    task automatic test_mc_order();
        logic [4:0] exp_rd[2] = '{5'd7, 5'd9};
        logic [PC_W-1:0] exp_pc[2] = '{32'h200, 32'h204};
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive_idle(); drive_ex(exp_pc[i], exp_rd[i], 1);
            tick();
            n_chk++; if ({bus.valid_O, bus.mc_count_O} !== {1'b0, CNT_W'(i + 1)}) begin
                n_fail++; $display("FAIL mc_issue%0d got v=%b cnt=%0d want 0/%0d", i, bus.valid_O, bus.mc_count_O, i + 1); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive_idle(); bus.mc_done_i = 1;
            #1;
            n_chk++; if ({bus.mc_ack_O, bus.ex_hold_O} !== 2'b10) begin
                n_fail++; $display("FAIL mc_ack%0d got ack=%b hold=%b want 1/0", i, bus.mc_ack_O, bus.ex_hold_O); end
            tick();
            n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O, bus.iSrc_to_Reg_O, bus.mc_result_sel_O, bus.ctrl_O, bus.mc_count_O}
                         !== {1'b1, exp_pc[i], exp_rd[i], 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, CNT_W'(1 - i)}) begin
                n_fail++; $display("FAIL mc_inject%0d got v=%b pc=%h rd=%0d we=%b isrc=%0d sel=%b cnt=%0d want rd=%0d", i, bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.RegI_Wr_En_O, bus.iSrc_to_Reg_O, bus.mc_result_sel_O, bus.mc_count_O, exp_rd[i]); end
        end
        @(negedge CLK);
        drive_idle();
        tick();
        n_chk++; if ({bus.valid_O, bus.mc_result_sel_O} !== 2'b00) begin
            n_fail++; $display("FAIL mc_after got v=%b sel=%b want 0/0", bus.valid_O, bus.mc_result_sel_O); end
    endtask

    task automatic test_collision();
        @(negedge CLK);
        drive_idle(); drive_ex(32'h208, 5'd3, 1);
        tick();
        @(negedge CLK);
        drive_idle(); drive_ex(32'h300, 5'd12, 0); bus.ctrl_I = 8'h20; bus.mc_done_i = 1;
        #1;
        n_chk++; if ({bus.ex_hold_O, bus.mc_ack_O} !== 2'b11) begin
            n_fail++; $display("FAIL coll_hold got hold=%b ack=%b want 1/1", bus.ex_hold_O, bus.mc_ack_O); end
        tick();
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.mc_result_sel_O} !== {1'b1, 32'h208, 5'd3, 1'b1}) begin
            n_fail++; $display("FAIL coll_inject got v=%b pc=%h rd=%0d sel=%b want 1/208/3/1", bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.mc_result_sel_O); end
        @(negedge CLK);
        bus.mc_done_i = 0;
        #1;
        n_chk++; if (bus.ex_hold_O !== 1'b0) begin n_fail++; $display("FAIL coll_release got hold=%b want 0", bus.ex_hold_O); end
        tick();
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O, bus.mc_result_sel_O} !== {1'b1, 32'h300, 5'd12, 8'h20, 1'b0}) begin
            n_fail++; $display("FAIL coll_capture got v=%b pc=%h rd=%0d ctrl=%h sel=%b want 1/300/12/20/0", bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.ctrl_O, bus.mc_result_sel_O); end
    endtask

    task automatic test_full();
        logic [4:0] drain[4] = '{5'd2, 5'd3, 5'd4, 5'd20};
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            drive_idle(); drive_ex(32'h400 + 32'(4 * i), 5'(i), 1);
            tick();
        end
        n_chk++; if ({bus.mc_count_O, bus.mc_full_O} !== {CNT_W'(4), 1'b1}) begin
            n_fail++; $display("FAIL full_fill got cnt=%0d full=%b want 4/1", bus.mc_count_O, bus.mc_full_O); end
        @(negedge CLK);
        drive_idle(); drive_ex(32'h500, 5'd20, 1);
        #1;
        n_chk++; if (bus.ex_hold_O !== 1'b1) begin n_fail++; $display("FAIL full_hold got %b want 1", bus.ex_hold_O); end
        tick();
        n_chk++; if ({bus.valid_O, bus.mc_count_O, bus.mc_full_O} !== {1'b0, CNT_W'(4), 1'b1}) begin
            n_fail++; $display("FAIL full_block got v=%b cnt=%0d full=%b want 0/4/1", bus.valid_O, bus.mc_count_O, bus.mc_full_O); end
        @(negedge CLK);
        bus.mc_done_i = 1;
        #1;
        n_chk++; if ({bus.mc_ack_O, bus.ex_hold_O} !== 2'b10) begin
            n_fail++; $display("FAIL full_swap_comb got ack=%b hold=%b want 1/0", bus.mc_ack_O, bus.ex_hold_O); end
        tick();
        n_chk++; if ({bus.ex_mem_rd, bus.PC_O, bus.mc_result_sel_O, bus.mc_count_O} !== {5'd1, 32'h404, 1'b1, CNT_W'(4)}) begin
            n_fail++; $display("FAIL full_swap got rd=%0d pc=%h sel=%b cnt=%0d want 1/404/1/4", bus.ex_mem_rd, bus.PC_O, bus.mc_result_sel_O, bus.mc_count_O); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive_idle(); bus.mc_done_i = 1;
            tick();
            n_chk++; if ({bus.valid_O, bus.ex_mem_rd, bus.mc_count_O} !== {1'b1, drain[i], CNT_W'(3 - i)}) begin
                n_fail++; $display("FAIL full_drain%0d got v=%b rd=%0d cnt=%0d want 1/%0d/%0d", i, bus.valid_O, bus.ex_mem_rd, bus.mc_count_O, drain[i], 3 - i); end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_error();
        @(negedge CLK);
        drive_idle(); bus.mc_done_i = 1;
        #1;
        n_chk++; if (bus.mc_ack_O !== 1'b0) begin n_fail++; $display("FAIL err_ack got %b want 0", bus.mc_ack_O); end
        tick();
        n_chk++; if ({bus.mc_err_O, bus.valid_O, bus.mc_count_O} !== {1'b1, 1'b0, CNT_W'(0)}) begin
            n_fail++; $display("FAIL err_set got err=%b v=%b cnt=%0d want 1/0/0", bus.mc_err_O, bus.valid_O, bus.mc_count_O); end
        @(negedge CLK);
        drive_idle();
        tick(); tick();
        n_chk++; if (bus.mc_err_O !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", bus.mc_err_O); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive_idle(); drive_ex(32'h600 + 32'(4 * i), 5'(13 + i), 1);
            tick();
        end
        @(negedge CLK);
        drive_idle(); drive_ex(32'h700, 5'd1, 0);
        tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_chk++; if ({bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.RegI_Wr_En_O, bus.mc_count_O, bus.mc_err_O} !== '0) begin
            n_fail++; $display("FAIL rstmid_now got v=%b pc=%h rd=%0d cnt=%0d err=%b want 0", bus.valid_O, bus.PC_O, bus.ex_mem_rd, bus.mc_count_O, bus.mc_err_O); end
        @(negedge CLK);
        drive_idle();
        rst_n = 1;
        bus.mc_done_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++; if ({bus.valid_O, bus.mc_result_sel_O, bus.mc_count_O} !== '0) begin
                n_fail++; $display("FAIL rstmid_noinj%0d got v=%b sel=%b cnt=%0d want 0", i, bus.valid_O, bus.mc_result_sel_O, bus.mc_count_O); end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_random();
        bit pop, push, hold;
        test_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            bus.stall_i = ($urandom % 8) == 0;
            bus.flush_i = ($urandom % 10) == 0;
            bus.valid_i = ($urandom % 4) != 0;
            bus.mc_issue_i = bus.valid_i && (($urandom % 3) == 0);
            bus.mc_done_i = ($urandom % 3) == 0;
            bus.PC_I = $urandom; bus.rd_i = 5'($urandom); bus.irs2_I = $urandom; bus.frs2_I = $urandom;
            bus.ctrl_I = CTRL_W'($urandom); bus.RegI_Wr_En_I = 1'($urandom); bus.RegF_Wr_En_I = 1'($urandom);
            bus.iSrc_to_Reg_I = 2'($urandom); bus.fSrc_to_Reg_I = 1'($urandom);
            #1;
            model_comb(pop, push, hold);
            n_chk++; if ({bus.mc_ack_O, bus.ex_hold_O, bus.mc_count_O, bus.mc_full_O} !== {pop, hold, CNT_W'(mq.size()), mq.size() == MC_DEPTH}) begin
                n_fail++; $display("FAIL rnd_comb c=%0d got ack=%b hold=%b cnt=%0d full=%b want %b/%b/%0d", c, bus.mc_ack_O, bus.ex_hold_O, bus.mc_count_O, bus.mc_full_O, pop, hold, mq.size()); end
            tick();
            n_chk++; if ({bus.valid_O, bus.ctrl_O, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O, bus.mc_result_sel_O, bus.mc_err_O} !== {m_valid, m_ctrl, m_regi, m_regf, m_sel, m_err}) begin
                n_fail++; $display("FAIL rnd_ctl c=%0d got v=%b ctrl=%h wi=%b wf=%b sel=%b err=%b want %b/%h/%b/%b/%b/%b", c, bus.valid_O, bus.ctrl_O, bus.RegI_Wr_En_O, bus.RegF_Wr_En_O, bus.mc_result_sel_O, bus.mc_err_O, m_valid, m_ctrl, m_regi, m_regf, m_sel, m_err); end
            if (m_valid) begin
                n_chk++; if ({bus.PC_O, bus.ex_mem_rd, bus.irs2_O, bus.frs2_O, bus.iSrc_to_Reg_O, bus.fSrc_to_Reg_O} !== {m_pc, m_rd, m_irs2, m_frs2, m_isrc, m_fsrc}) begin
                    n_fail++; $display("FAIL rnd_data c=%0d got pc=%h rd=%0d irs2=%h frs2=%h want pc=%h rd=%0d irs2=%h frs2=%h", c, bus.PC_O, bus.ex_mem_rd, bus.irs2_O, bus.frs2_O, m_pc, m_rd, m_irs2, m_frs2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stall_flush();
        test_mc_order();
        test_collision();
        test_full();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
